// File: rtl/i2c_target.sv
// I2C target (slave) with a fixed 7-bit address, byte-wide receive and transmit handshakes.
// The FSM runs on oversampled, synchronized SCL/SDA; SCL is never driven (no clock stretching).
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WRITE,
        S_WRITE_ACK,
        S_READ,
        S_READ_ACK
    } state_t;

    logic       r_scl_p0, r_scl_p1, r_scl_p2;
    logic       r_sda_p0, r_sda_p1, r_sda_p2;
    logic       w_scl, w_scl_prev, w_sda, w_sda_prev;
    logic       w_scl_rise, w_scl_fall, w_start, w_stop;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic       r_rw, w_rw_nxt;
    logic       r_byte_done, w_byte_done_nxt;
    logic       r_rx_load, w_rx_load_nxt;
    logic       r_sda_oe, w_sda_oe_nxt;
    logic [7:0] r_rx_data, w_rx_data_nxt;
    logic       r_rx_valid, w_rx_valid_nxt;
    logic [6:0] r_tx_shift, w_tx_shift_nxt;
    logic       w_tx_req;

    // Stage p0/p1: metastability synchronizers; p2: history flop for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_p0 <= 1'b1;
            r_scl_p1 <= 1'b1;
            r_scl_p2 <= 1'b1;
            r_sda_p0 <= 1'b1;
            r_sda_p1 <= 1'b1;
            r_sda_p2 <= 1'b1;
        end else begin
            r_scl_p0 <= scl_i;
            r_scl_p1 <= r_scl_p0;
            r_scl_p2 <= r_scl_p1;
            r_sda_p0 <= sda_i;
            r_sda_p1 <= r_sda_p0;
            r_sda_p2 <= r_sda_p1;
        end
    end

    assign w_scl      = r_scl_p1;
    assign w_scl_prev = r_scl_p2;
    assign w_sda      = r_sda_p1;
    assign w_sda_prev = r_sda_p2;
    assign w_scl_rise = w_scl & ~w_scl_prev;
    assign w_scl_fall = ~w_scl & w_scl_prev;
    assign w_start    = w_scl & w_scl_prev & ~w_sda & w_sda_prev;
    assign w_stop     = w_scl & w_scl_prev & w_sda & ~w_sda_prev;

    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_cnt_nxt       = r_cnt;
        w_rw_nxt        = r_rw;
        w_byte_done_nxt = r_byte_done;
        w_rx_load_nxt   = 1'b0;
        w_sda_oe_nxt    = r_sda_oe;
        w_rx_data_nxt   = r_rx_data;
        w_rx_valid_nxt  = 1'b0;
        w_tx_shift_nxt  = r_tx_shift;
        w_tx_req        = 1'b0;

        if (w_start) begin
            w_state_nxt     = S_ADDR;
            w_cnt_nxt       = 3'd0;
            w_byte_done_nxt = 1'b0;
            w_sda_oe_nxt    = 1'b0;
        end else if (w_stop) begin
            w_state_nxt     = S_IDLE;
            w_byte_done_nxt = 1'b0;
            w_sda_oe_nxt    = 1'b0;
        end else begin
            // A completed write byte is published one cycle after its last bit lands
            if (r_rx_load) begin
                w_rx_data_nxt  = r_shift;
                w_rx_valid_nxt = 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                end
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = {r_shift[6:0], w_sda};
                        w_cnt_nxt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            if (r_shift[6:0] == TARGET_ADDR) begin
                                w_rw_nxt        = w_sda;
                                w_byte_done_nxt = 1'b1;
                            end else begin
                                w_state_nxt = S_IDLE;
                            end
                        end
                    end else if (w_scl_fall && r_byte_done) begin
                        w_byte_done_nxt = 1'b0;
                        w_sda_oe_nxt    = 1'b1;
                        w_state_nxt     = S_ADDR_ACK;
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (r_rw) begin
                            w_tx_req       = 1'b1;
                            w_tx_shift_nxt = tx_data[6:0];
                            w_sda_oe_nxt   = ~tx_data[7];
                            w_cnt_nxt      = 3'd0;
                            w_state_nxt    = S_READ;
                        end else begin
                            w_sda_oe_nxt = 1'b0;
                            w_state_nxt  = S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = {r_shift[6:0], w_sda};
                        w_cnt_nxt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_rx_load_nxt   = 1'b1;
                            w_byte_done_nxt = 1'b1;
                        end
                    end else if (w_scl_fall && r_byte_done) begin
                        w_byte_done_nxt = 1'b0;
                        w_sda_oe_nxt    = 1'b1;
                        w_state_nxt     = S_WRITE_ACK;
                    end
                end
                S_WRITE_ACK: begin
                    if (w_scl_fall) begin
                        w_sda_oe_nxt = 1'b0;
                        w_state_nxt  = S_WRITE;
                    end
                end
                S_READ: begin
                    // r_cnt counts bits already on the bus beyond bit 7
                    if (w_scl_fall) begin
                        if (r_cnt == 3'd7) begin
                            w_sda_oe_nxt = 1'b0;
                            w_cnt_nxt    = 3'd0;
                            w_state_nxt  = S_READ_ACK;
                        end else begin
                            w_sda_oe_nxt   = ~r_tx_shift[6];
                            w_tx_shift_nxt = {r_tx_shift[5:0], 1'b0};
                            w_cnt_nxt      = r_cnt + 3'd1;
                        end
                    end
                end
                S_READ_ACK: begin
                    if (w_scl_rise && w_sda) begin
                        w_state_nxt = S_IDLE;
                    end else if (w_scl_fall) begin
                        w_tx_req       = 1'b1;
                        w_tx_shift_nxt = tx_data[6:0];
                        w_sda_oe_nxt   = ~tx_data[7];
                        w_cnt_nxt      = 3'd0;
                        w_state_nxt    = S_READ;
                    end
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shift     <= 8'h00;
            r_cnt       <= 3'd0;
            r_rw        <= 1'b0;
            r_byte_done <= 1'b0;
            r_rx_load   <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_tx_shift  <= 7'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rw        <= w_rw_nxt;
            r_byte_done <= w_byte_done_nxt;
            r_rx_load   <= w_rx_load_nxt;
            r_sda_oe    <= w_sda_oe_nxt;
            r_rx_data   <= w_rx_data_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_tx_shift  <= w_tx_shift_nxt;
        end
    end

    assign sda_oe   = r_sda_oe;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign tx_req   = w_tx_req & ~reset;
    assign busy     = (r_state == S_ADDR_ACK) || (r_state == S_WRITE) ||
                      (r_state == S_WRITE_ACK) || (r_state == S_READ) ||
                      (r_state == S_READ_ACK);

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a behavioural I2C master on an open-drain bus, directed scenarios
// plus randomized transactions compared against expected bus-level results.
module tb_i2c_target;

    localparam int Q = 80;  // quarter SCL period in ns; SCL = 32 system clocks

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m, sda_m;
    logic [7:0] tx_data;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, busy;
    wire        sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target #(.TARGET_ADDR(7'h50)) dut (
        .clk     (clk),
        .reset   (reset),
        .scl_i   (scl_m),
        .sda_i   (sda_bus),
        .sda_oe  (sda_oe),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .tx_data (tx_data),
        .tx_req  (tx_req),
        .busy    (busy)
    );

    int         n_checks = 0;
    int         n_pass = 0;
    int         rx_cnt = 0;
    int         tx_cnt = 0;
    int         dbl_pulse = 0;
    int         oe_scl_viol = 0;
    bit         oe_seen = 0;
    logic       oe_q = 1'b0, rxv_q = 1'b0, txr_q = 1'b0, rst_q = 1'b1;
    logic [7:0] rx_log[$];

    // Passive bus/handshake observer
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rx_log.push_back(rx_data);
            rx_cnt++;
        end
        if (tx_req === 1'b1) tx_cnt++;
        if ((rx_valid === 1'b1 && rxv_q === 1'b1) || (tx_req === 1'b1 && txr_q === 1'b1)) dbl_pulse++;
        if (sda_oe === 1'b1) oe_seen = 1;
        if (sda_oe !== oe_q && scl_m === 1'b1 && !reset && !rst_q) oe_scl_viol++;
        oe_q  = sda_oe;
        rxv_q = rx_valid;
        txr_q = tx_req;
        rst_q = reset;
    end

    task automatic i2c_start();
        if (scl_m) begin
            sda_m = 1'b1; #Q;
        end else begin
            sda_m = 1'b1; #Q;
            scl_m = 1'b1; #Q;
        end
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
        #Q;
    endtask

    task automatic put_bit(input logic b);
        sda_m = b; #Q;
        scl_m = 1'b1; #(2 * Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        b = sda_bus; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(output logic [7:0] d, input logic nack, input logic [7:0] next_tx);
        logic [7:0] tmp;
        logic       b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            tmp[i] = b;
        end
        d = tmp;
        tx_data = next_tx;
        put_bit(nack);
    endtask

    task automatic test_reset();
        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe: got %b want 0", sda_oe); else n_pass++;
        n_checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h want 00", rx_data); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b want 0", rx_valid); else n_pass++;
        n_checks++; if (tx_req !== 1'b0) $display("FAIL reset_tx_req: got %b want 0", tx_req); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_write();
        logic a0, a1;
        rx_log.delete(); rx_cnt = 0;
        i2c_start();
        put_byte(8'hA0, a0);
        put_byte(8'h3C, a1);
        n_checks++; if (a0 !== 1'b0) $display("FAIL wr_addr_ack: got %b want 0", a0); else n_pass++;
        n_checks++; if (a1 !== 1'b0) $display("FAIL wr_data_ack: got %b want 0", a1); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL wr_busy: got %b want 1", busy); else n_pass++;
        i2c_stop();
        #(2 * Q);
        n_checks++; if (busy !== 1'b0) $display("FAIL wr_busy_after_stop: got %b want 0", busy); else n_pass++;
        n_checks++; if (rx_cnt !== 1) $display("FAIL wr_rx_valid_count: got %0d want 1", rx_cnt); else n_pass++;
        n_checks++; if (rx_data !== 8'h3C) $display("FAIL wr_rx_data: got %h want 3c", rx_data); else n_pass++;
    endtask

    task automatic test_addr_mismatch();
        logic a0, a1;
        rx_cnt = 0; oe_seen = 0;
        i2c_start();
        put_byte(8'hA2, a0);
        put_byte(8'h55, a1);
        n_checks++; if (a0 !== 1'b1) $display("FAIL mm_addr_nack: got %b want 1", a0); else n_pass++;
        n_checks++; if (a1 !== 1'b1) $display("FAIL mm_data_nack: got %b want 1", a1); else n_pass++;
        n_checks++; if (oe_seen !== 1'b0) $display("FAIL mm_sda_oe_seen: got %b want 0", oe_seen); else n_pass++;
        n_checks++; if (rx_cnt !== 0) $display("FAIL mm_rx_valid_count: got %0d want 0", rx_cnt); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mm_busy: got %b want 0", busy); else n_pass++;
        i2c_stop();
    endtask

    task automatic test_read();
        logic       a0;
        logic [7:0] d0, d1;
        tx_cnt = 0; tx_data = 8'h96;
        i2c_start();
        put_byte(8'hA1, a0);
        get_byte(d0, 1'b0, 8'h5A);
        get_byte(d1, 1'b1, 8'h00);
        n_checks++; if (a0 !== 1'b0) $display("FAIL rd_addr_ack: got %b want 0", a0); else n_pass++;
        n_checks++; if (d0 !== 8'h96) $display("FAIL rd_byte0: got %h want 96", d0); else n_pass++;
        n_checks++; if (d1 !== 8'h5A) $display("FAIL rd_byte1: got %h want 5a", d1); else n_pass++;
        n_checks++; if (tx_cnt !== 2) $display("FAIL rd_tx_req_count: got %0d want 2", tx_cnt); else n_pass++;
        n_checks++; if (sda_oe !== 1'b0) $display("FAIL rd_sda_oe_after_nack: got %b want 0", sda_oe); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rd_busy_after_nack: got %b want 0", busy); else n_pass++;
        i2c_stop();
    endtask

    task automatic test_repeated_start();
        logic       a0, a1, a2;
        logic [7:0] d0;
        rx_cnt = 0; tx_cnt = 0; tx_data = 8'hC3;
        i2c_start();
        put_byte(8'hA0, a0);
        put_byte(8'h01, a1);
        i2c_start();
        put_byte(8'hA1, a2);
        get_byte(d0, 1'b1, 8'h00);
        i2c_stop();
        n_checks++; if ({a0, a1, a2} !== 3'b000) $display("FAIL rs_acks: got %b want 000", {a0, a1, a2}); else n_pass++;
        n_checks++; if (rx_cnt !== 1) $display("FAIL rs_rx_valid_count: got %0d want 1", rx_cnt); else n_pass++;
        n_checks++; if (rx_data !== 8'h01) $display("FAIL rs_rx_data: got %h want 01", rx_data); else n_pass++;
        n_checks++; if (tx_cnt !== 1) $display("FAIL rs_tx_req_count: got %0d want 1", tx_cnt); else n_pass++;
        n_checks++; if (d0 !== 8'hC3) $display("FAIL rs_read_byte: got %h want c3", d0); else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        logic       a0, b, b0, b1;
        logic [4:0] rest;
        tx_data = 8'h00;
        i2c_start();
        put_byte(8'hA1, a0);
        n_checks++; if (a0 !== 1'b0) $display("FAIL rmr_addr_ack: got %b want 0", a0); else n_pass++;
        repeat (3) get_bit(b);
        n_checks++; if (sda_oe !== 1'b1) $display("FAIL rmr_oe_bit4: got %b want 1", sda_oe); else n_pass++;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (sda_oe !== 1'b0) $display("FAIL rmr_oe_after_reset: got %b want 0", sda_oe); else n_pass++;
        reset = 1'b0;
        oe_seen = 0; tx_cnt = 0;
        for (int i = 4; i >= 0; i--) begin
            get_bit(b);
            rest[i] = b;
        end
        put_bit(1'b1);
        n_checks++; if (rest !== 5'h1F) $display("FAIL rmr_bus_released: got %h want 1f", rest); else n_pass++;
        n_checks++; if (oe_seen !== 1'b0) $display("FAIL rmr_oe_seen: got %b want 0", oe_seen); else n_pass++;
        n_checks++; if (tx_cnt !== 0) $display("FAIL rmr_tx_req_count: got %0d want 0", tx_cnt); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rmr_busy: got %b want 0", busy); else n_pass++;
        i2c_stop();
        i2c_start();
        put_byte(8'hA0, b0);
        put_byte(8'h77, b1);
        i2c_stop();
        n_checks++; if ({b0, b1} !== 2'b00) $display("FAIL rmr_new_acks: got %b want 00", {b0, b1}); else n_pass++;
        n_checks++; if (rx_data !== 8'h77) $display("FAIL rmr_new_rx_data: got %h want 77", rx_data); else n_pass++;
    endtask

    task automatic test_stop_mid_byte();
        logic a0;
        i2c_start();
        put_byte(8'hA0, a0);
        rx_cnt = 0;
        put_bit(1'b1);
        put_bit(1'b0);
        put_bit(1'b1);
        i2c_stop();
        n_checks++; if (a0 !== 1'b0) $display("FAIL smb_addr_ack: got %b want 0", a0); else n_pass++;
        n_checks++; if (rx_cnt !== 0) $display("FAIL smb_rx_valid_count: got %0d want 0", rx_cnt); else n_pass++;
        n_checks++; if (sda_oe !== 1'b0) $display("FAIL smb_sda_oe: got %b want 0", sda_oe); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL smb_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_random();
        logic       match, is_read, a;
        logic [6:0] addr;
        int         n, want_cnt;
        logic [7:0] data[3];
        logic [7:0] d, got, want, nxt;
        for (int t = 0; t < 10; t++) begin
            match   = ($urandom_range(0, 3) != 0);
            addr    = 7'h50;
            if (!match) while (addr == 7'h50) addr = 7'($urandom_range(0, 127));
            is_read = 1'($urandom_range(0, 1));
            n       = $urandom_range(1, 3);
            for (int k = 0; k < 3; k++) data[k] = 8'($urandom_range(0, 255));
            rx_log.delete(); rx_cnt = 0; tx_cnt = 0; tx_data = data[0];
            i2c_start();
            put_byte({addr, is_read}, a);
            n_checks++; if (a !== !match) $display("FAIL rnd%0d_addr_ack: got %b want %b", t, a, !match); else n_pass++;
            if (is_read) begin
                for (int k = 0; k < n; k++) begin
                    nxt = (k < n - 1) ? data[(k + 1) % 3] : 8'h00;
                    get_byte(d, (k == n - 1), nxt);
                    want = match ? data[k] : 8'hFF;
                    n_checks++; if (d !== want) $display("FAIL rnd%0d_read%0d: got %h want %h", t, k, d, want); else n_pass++;
                end
                i2c_stop();
                want_cnt = match ? n : 0;
                n_checks++; if (tx_cnt !== want_cnt) $display("FAIL rnd%0d_tx_req_count: got %0d want %0d", t, tx_cnt, want_cnt); else n_pass++;
            end else begin
                for (int k = 0; k < n; k++) begin
                    put_byte(data[k], a);
                    n_checks++; if (a !== !match) $display("FAIL rnd%0d_data%0d_ack: got %b want %b", t, k, a, !match); else n_pass++;
                end
                i2c_stop();
                #(2 * Q);
                want_cnt = match ? n : 0;
                n_checks++; if (rx_cnt !== want_cnt) $display("FAIL rnd%0d_rx_valid_count: got %0d want %0d", t, rx_cnt, want_cnt); else n_pass++;
                if (match) begin
                    for (int k = 0; k < n; k++) begin
                        got = (rx_log.size() > k) ? rx_log[k] : 8'hxx;
                        n_checks++; if (got !== data[k]) $display("FAIL rnd%0d_rx%0d: got %h want %h", t, k, got, data[k]); else n_pass++;
                    end
                end
            end
        end
    endtask

    task automatic test_protocol_rules();
        n_checks++; if (dbl_pulse !== 0) $display("FAIL pulse_width: got %0d long pulses want 0", dbl_pulse); else n_pass++;
        n_checks++; if (oe_scl_viol !== 0) $display("FAIL oe_while_scl_high: got %0d changes want 0", oe_scl_viol); else n_pass++;
    endtask

    initial begin
        reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
        @(negedge clk);
        test_reset();
        test_write();
        test_addr_mismatch();
        test_read();
        test_repeated_start();
        test_reset_mid_read();
        test_stop_mid_byte();
        test_random();
        test_protocol_rules();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
